// File: rtl/p2s.sv
// p2s: parallel-to-serial spike serializer.
// Accepts P-bit words on spike_p/in_valid/in_ready and emits them one bit per
// transfer on spike_s/valid_s/ready_s, with last marking each word's final bit.
// A one-word holding buffer lets back-to-back words stream without bubbles.
// Optional build macro P2S_LSB_FIRST_EN: send spike_p[0] first instead of
// spike_p[P-1]; handshake, latency and last timing are unchanged.
//
// Handshake: on both sides a transfer happens at a rising edge where
// valid and ready are both high. A source holds valid (and data) stable
// until the transfer; valid never depends on ready. Here in_ready is the
// only combinational output and depends only on ready_s and local state.
module p2s #(
    parameter int P = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [P-1:0] spike_p,
    input  logic         in_valid,
    output logic         in_ready,
    output logic         spike_s,
    output logic         valid_s,
    input  logic         ready_s,
    output logic         last,
    output logic         busy
);

    localparam int CW = $clog2(P);
    localparam logic [CW-1:0] CNT_FULL = CW'(P - 1);

    logic [P-1:0]  hold_q, hold_d;
    logic          hold_v_q, hold_v_d;
    logic [P-1:0]  sh_q, sh_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          spike_s_q, spike_s_d;
    logic          valid_s_q, valid_s_d;
    logic          last_q, last_d;

    logic adv;
    logic take;
    logic accept;

    // Output slot free or draining; held word moves to the shifter when the
    // shifter is empty; a new word may enter when the holding slot frees up.
    always_comb begin
        adv    = ~valid_s_q | ready_s;
        take   = adv & (cnt_q == '0) & hold_v_q;
        accept = in_valid & in_ready;
    end

    assign in_ready = ~hold_v_q | take;
    assign spike_s  = spike_s_q;
    assign valid_s  = valid_s_q;
    assign last     = last_q;
    assign busy     = hold_v_q | (cnt_q != '0) | valid_s_q;

    // Next-state: holding buffer refill, then shift / load / idle on advance.
    always_comb begin
        hold_d    = hold_q;
        hold_v_d  = hold_v_q;
        sh_d      = sh_q;
        cnt_d     = cnt_q;
        spike_s_d = spike_s_q;
        valid_s_d = valid_s_q;
        last_d    = last_q;

        if (take) begin
            hold_v_d = 1'b0;
        end
        if (accept) begin
            hold_d   = spike_p;
            hold_v_d = 1'b1;
        end

        if (adv) begin
            if (cnt_q != '0) begin
`ifdef P2S_LSB_FIRST_EN
                spike_s_d = sh_q[0];
                sh_d      = sh_q >> 1;
`else
                spike_s_d = sh_q[P-1];
                sh_d      = sh_q << 1;
`endif
                cnt_d     = cnt_q - CW'(1);
                valid_s_d = 1'b1;
                last_d    = (cnt_q == CW'(1));
            end else if (take) begin
`ifdef P2S_LSB_FIRST_EN
                spike_s_d = hold_q[0];
                sh_d      = hold_q >> 1;
`else
                spike_s_d = hold_q[P-1];
                sh_d      = hold_q << 1;
`endif
                cnt_d     = CNT_FULL;
                valid_s_d = 1'b1;
                last_d    = 1'b0;
            end else begin
                spike_s_d = 1'b0;
                valid_s_d = 1'b0;
                last_d    = 1'b0;
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            hold_q    <= '0;
            hold_v_q  <= 1'b0;
            sh_q      <= '0;
            cnt_q     <= '0;
            spike_s_q <= 1'b0;
            valid_s_q <= 1'b0;
            last_q    <= 1'b0;
        end else begin
            hold_q    <= hold_d;
            hold_v_q  <= hold_v_d;
            sh_q      <= sh_d;
            cnt_q     <= cnt_d;
            spike_s_q <= spike_s_d;
            valid_s_q <= valid_s_d;
            last_q    <= last_d;
        end
    end

endmodule

// File: tb/tb_p2s.sv
// tb_p2s: self-checking bench for p2s (P=4).
// Expected serial bits come from a word-level model: each accepted word is
// expanded into its P bits in send order with last on the final one.
module tb_p2s;
  localparam int P = 4;

  logic         clk;
  logic         rst;
  logic [P-1:0] spike_p;
  logic         in_valid;
  logic         in_ready;
  logic         spike_s;
  logic         valid_s;
  logic         ready_s;
  logic         last;
  logic         busy;

  int n_vec;
  int n_err;
  logic rand_ready;

  // expected {last, bit} per serial transfer
  logic [1:0] exp_q[$];

  p2s #(.P(P)) dut (
    .clk     (clk),
    .rst     (rst),
    .spike_p (spike_p),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .spike_s (spike_s),
    .valid_s (valid_s),
    .ready_s (ready_s),
    .last    (last),
    .busy    (busy)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: word -> ordered serial bits
  task automatic push_model(input logic [P-1:0] w);
    for (int i = 0; i < P; i++) begin
`ifdef P2S_LSB_FIRST_EN
      exp_q.push_back({(i == P - 1), w[i]});
`else
      exp_q.push_back({(i == P - 1), w[P-1-i]});
`endif
    end
  endtask

  // advance one cycle; inputs change 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) ready_s = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send_word(input logic [P-1:0] w);
    in_valid = 1'b1;
    spike_p  = w;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin
        push_model(w);
        tick();
        in_valid = 1'b0;
        spike_p  = P'($urandom);
        return;
      end
      tick();
    end
    check("send_timeout", 1, 0);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy) break;
      tick();
    end
    check("drain_queue_empty", exp_q.size(), 0);
    check("drain_busy", busy, 0);
    check("drain_valid_s", valid_s, 0);
    tick();
  endtask

  // monitor: pop and compare on every serial transfer; check stall hold
  initial begin
    logic [1:0] e;
    logic       stall_prev;
    logic [2:0] prev_out;
    stall_prev = 1'b0;
    prev_out   = '0;
    forever begin
      @(negedge clk);
      if (valid_s && ready_s) begin
        if (exp_q.size() == 0) begin
          check("unexpected_bit", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("serial_bit", {last, spike_s}, e);
        end
      end
      if (stall_prev) check("stall_hold", {valid_s, last, spike_s}, prev_out);
      stall_prev = rst && valid_s && !ready_s;
      prev_out   = {valid_s, last, spike_s};
    end
  end

  // stimulus
  initial begin
    int run;
    n_vec      = 0;
    n_err      = 0;
    rand_ready = 1'b0;
    rst        = 1'b0;
    spike_p    = '0;
    in_valid   = 1'b0;
    ready_s    = 1'b1;

    // reset state
    repeat (3) tick();
    @(negedge clk);
    check("rst_outputs", {spike_s, valid_s, last, busy}, 4'b0000);
    tick();
    rst = 1'b1;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    tick();

    // single word, latency and bit order
    send_word(4'b1011);
    @(negedge clk);
    check("lat_idle_valid", valid_s, 0);
    check("lat_idle_busy", busy, 1);
    tick();
    @(negedge clk);
    check("lat_first_valid", valid_s, 1);
    tick();
    drain();

    // back-to-back stream: 12 contiguous valid cycles
    run = 0;
    fork
      begin
        send_word(4'hA);
        send_word(4'h5);
        send_word(4'hF);
      end
      begin
        for (int i = 0; i < 10; i++) begin
          @(negedge clk);
          if (valid_s) break;
        end
        while (valid_s && run < 20) begin
          run++;
          @(negedge clk);
        end
      end
    join
    check("stream_run_len", run, 12);
    drain();

    // stall for 3 cycles after the 2nd bit
    send_word(4'hC);
    tick();
    tick();
    ready_s = 1'b0;
    repeat (3) tick();
    ready_s = 1'b1;
    drain();

    // reset mid-word with another word held
    send_word(4'h9);
    send_word(4'h3);
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("midrst_outputs", {spike_s, valid_s, last, busy}, 4'b0000);
    check("midrst_in_ready", in_ready, 1);
    tick();
    send_word(4'h6);
    drain();

    // random words, random gaps, random backpressure
    rand_ready = 1'b1;
    for (int k = 0; k < 60; k++) begin
      send_word(P'($urandom));
      repeat ($urandom_range(0, 3)) tick();
    end
    drain();
    rand_ready = 1'b0;
    ready_s    = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
